// File: rtl/cva6_lsu_issue_arbiter_if.sv
// Issue-side and LSU-side handshake bundle for the LSU issue arbiter.
// Signal suffixes are written from the arbiter's point of view.
interface cva6_lsu_issue_arbiter_if;
  logic        req0_valid_i;
  logic [31:0] req0_instr_i;
  logic        req0_is_load_i;
  logic        req0_ready_o;
  logic        req1_valid_i;
  logic [31:0] req1_instr_i;
  logic        req1_is_load_i;
  logic        req1_ready_o;
  logic        lsu_valid_o;
  logic [31:0] lsu_instr_o;
  logic        lsu_is_load_o;
  logic        lsu_ready_i;
  logic        load_mem_resp_i;
  logic        store_mem_resp_i;

  // Arbiter side
  modport slave (
    input  req0_valid_i, req0_instr_i, req0_is_load_i,
    input  req1_valid_i, req1_instr_i, req1_is_load_i,
    input  lsu_ready_i, load_mem_resp_i, store_mem_resp_i,
    output req0_ready_o, req1_ready_o,
    output lsu_valid_o, lsu_instr_o, lsu_is_load_o
  );

  // Issue stage / LSU side
  modport master (
    output req0_valid_i, req0_instr_i, req0_is_load_i,
    output req1_valid_i, req1_instr_i, req1_is_load_i,
    output lsu_ready_i, load_mem_resp_i, store_mem_resp_i,
    input  req0_ready_o, req1_ready_o,
    input  lsu_valid_o, lsu_instr_o, lsu_is_load_o
  );
endinterface

// File: rtl/cva6_lsu_issue_arbiter.sv
// Round-robin arbiter sharing the single LSU issue port between two
// requesters. Allows one outstanding load and one outstanding store, blocks
// loads that alias the outstanding store, and flags timeouts and stray
// responses with sticky error bits.
module cva6_lsu_issue_arbiter #(
  parameter int unsigned ADDR_CMP_W     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CTR_W          = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  cva6_lsu_issue_arbiter_if.slave bus,
  output logic                   load_busy_o,
  output logic                   store_busy_o,
  output logic                   hazard_stall_o,
  output logic                   timeout_o,
  output logic                   spurious_resp_o
);

  localparam logic [CTR_W-1:0] CNT_LAST = CTR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CTR_W-1:0] CNT_PRE  = CTR_W'(TIMEOUT_CYCLES - 2);

  logic                  lsu_vld_q, lsu_vld_d;
  logic [31:0]           lsu_instr_q, lsu_instr_d;
  logic                  lsu_is_load_q, lsu_is_load_d;
  logic                  load_busy_q, load_busy_d;
  logic                  store_busy_q, store_busy_d;
  logic [ADDR_CMP_W-1:0] store_addr_q, store_addr_d;
  logic                  rr_q, rr_d;
  logic [CTR_W-1:0]      load_cnt_q, load_cnt_d;
  logic [CTR_W-1:0]      store_cnt_q, store_cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  spurious_q, spurious_d;

  logic        issue_free;
  logic        haz0, haz1;
  logic        elig0, elig1;
  logic        gnt0, gnt1, gnt_any;
  logic [31:0] gnt_instr;
  logic        gnt_is_load, gnt_load, gnt_store;

  // The issue slot can be refilled in the same cycle the LSU drains it.
  assign issue_free = !lsu_vld_q || bus.lsu_ready_i;

  // A load aliasing the in-flight store must wait for that store to finish.
  assign haz0 = store_busy_q && (store_addr_q == bus.req0_instr_i[ADDR_CMP_W-1:0]);
  assign haz1 = store_busy_q && (store_addr_q == bus.req1_instr_i[ADDR_CMP_W-1:0]);

  assign elig0 = bus.req0_valid_i && issue_free &&
                 (bus.req0_is_load_i ? (!load_busy_q && !haz0) : !store_busy_q);
  assign elig1 = bus.req1_valid_i && issue_free &&
                 (bus.req1_is_load_i ? (!load_busy_q && !haz1) : !store_busy_q);

  // rr_q == 0 favours req0 when both are eligible.
  assign gnt0    = elig0 && (!elig1 || !rr_q);
  assign gnt1    = elig1 && (!elig0 ||  rr_q);
  assign gnt_any = gnt0 || gnt1;

  assign gnt_instr   = gnt1 ? bus.req1_instr_i   : bus.req0_instr_i;
  assign gnt_is_load = gnt1 ? bus.req1_is_load_i : bus.req0_is_load_i;
  assign gnt_load    = gnt_any &&  gnt_is_load;
  assign gnt_store   = gnt_any && !gnt_is_load;

  assign bus.req0_ready_o  = gnt0;
  assign bus.req1_ready_o  = gnt1;
  assign bus.lsu_valid_o   = lsu_vld_q;
  assign bus.lsu_instr_o   = lsu_instr_q;
  assign bus.lsu_is_load_o = lsu_is_load_q;
  assign load_busy_o       = load_busy_q;
  assign store_busy_o      = store_busy_q;
  assign hazard_stall_o    = (bus.req0_valid_i && bus.req0_is_load_i && haz0) ||
                             (bus.req1_valid_i && bus.req1_is_load_i && haz1);
  assign timeout_o         = timeout_q;
  assign spurious_resp_o   = spurious_q;

  // Next-state logic for issue register, slots, pointer, counters and errors.
  always_comb begin
    lsu_vld_d     = lsu_vld_q;
    lsu_instr_d   = lsu_instr_q;
    lsu_is_load_d = lsu_is_load_q;
    if (gnt_any) begin
      lsu_vld_d     = 1'b1;
      lsu_instr_d   = gnt_instr;
      lsu_is_load_d = gnt_is_load;
    end else if (bus.lsu_ready_i) begin
      lsu_vld_d     = 1'b0;
    end

    rr_d = rr_q;
    if (elig0 && elig1) rr_d = ~rr_q;

    // A grant can only hit an idle slot, so grant-set never races resp-clear.
    load_busy_d = load_busy_q;
    if (gnt_load)                 load_busy_d = 1'b1;
    else if (bus.load_mem_resp_i) load_busy_d = 1'b0;

    store_busy_d = store_busy_q;
    if (gnt_store)                 store_busy_d = 1'b1;
    else if (bus.store_mem_resp_i) store_busy_d = 1'b0;

    store_addr_d = store_addr_q;
    if (gnt_store) store_addr_d = gnt_instr[ADDR_CMP_W-1:0];

    load_cnt_d = load_cnt_q;
    if (gnt_load)                                 load_cnt_d = '0;
    else if (load_busy_q && load_cnt_q != CNT_LAST) load_cnt_d = load_cnt_q + CTR_W'(1);

    store_cnt_d = store_cnt_q;
    if (gnt_store)                                   store_cnt_d = '0;
    else if (store_busy_q && store_cnt_q != CNT_LAST) store_cnt_d = store_cnt_q + CTR_W'(1);

    // Set on the edge where a still-busy counter steps onto its last value,
    // so the flag is visible during the TIMEOUT_CYCLES-th busy cycle.
    timeout_d = timeout_q ||
                (load_busy_q  && !bus.load_mem_resp_i  && load_cnt_q  == CNT_PRE) ||
                (store_busy_q && !bus.store_mem_resp_i && store_cnt_q == CNT_PRE);

    spurious_d = spurious_q ||
                 (bus.load_mem_resp_i  && !load_busy_q) ||
                 (bus.store_mem_resp_i && !store_busy_q);
  end

  // State registers; reset clears everything, dropping in-flight ops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lsu_vld_q     <= 1'b0;
      lsu_instr_q   <= '0;
      lsu_is_load_q <= 1'b0;
      load_busy_q   <= 1'b0;
      store_busy_q  <= 1'b0;
      store_addr_q  <= '0;
      rr_q          <= 1'b0;
      load_cnt_q    <= '0;
      store_cnt_q   <= '0;
      timeout_q     <= 1'b0;
      spurious_q    <= 1'b0;
    end else begin
      lsu_vld_q     <= lsu_vld_d;
      lsu_instr_q   <= lsu_instr_d;
      lsu_is_load_q <= lsu_is_load_d;
      load_busy_q   <= load_busy_d;
      store_busy_q  <= store_busy_d;
      store_addr_q  <= store_addr_d;
      rr_q          <= rr_d;
      load_cnt_q    <= load_cnt_d;
      store_cnt_q   <= store_cnt_d;
      timeout_q     <= timeout_d;
      spurious_q    <= spurious_d;
    end
  end

endmodule

// File: tb/tb_cva6_lsu_issue_arbiter.sv
// Directed bench for cva6_lsu_issue_arbiter. Inputs change 1ns after the
// rising edge and outputs are sampled 2ns after it.
module tb_cva6_lsu_issue_arbiter;

  logic clk;
  logic rst;
  logic load_busy, store_busy, hazard_stall, timeout, spurious;
  int   checks = 0;
  int   errors = 0;

  cva6_lsu_issue_arbiter_if bus ();

  cva6_lsu_issue_arbiter #(
    .ADDR_CMP_W(12), .TIMEOUT_CYCLES(64), .CTR_W(7)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus),
    .load_busy_o    (load_busy),
    .store_busy_o   (store_busy),
    .hazard_stall_o (hazard_stall),
    .timeout_o      (timeout),
    .spurious_resp_o(spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.req0_valid_i = 0; bus.req0_instr_i = '0; bus.req0_is_load_i = 0;
    bus.req1_valid_i = 0; bus.req1_instr_i = '0; bus.req1_is_load_i = 0;
    bus.lsu_ready_i = 1; bus.load_mem_resp_i = 0; bus.store_mem_resp_i = 0;

    // Reset state
    #3;
    chk1("rst_lsu_valid", bus.lsu_valid_o, 1'b0);
    chk32("rst_lsu_instr", bus.lsu_instr_o, 32'h0);
    chk1("rst_load_busy", load_busy, 1'b0);
    chk1("rst_store_busy", store_busy, 1'b0);
    chk1("rst_timeout", timeout, 1'b0);
    chk1("rst_spurious", spurious, 1'b0);
    cyc();
    rst = 1'b0;

    // Single load from req0
    cyc();
    bus.req0_valid_i = 1; bus.req0_instr_i = 32'hcad; bus.req0_is_load_i = 1;
    #1;
    chk1("s1_rdy0_c0", bus.req0_ready_o, 1'b1);
    chk1("s1_vld_c0", bus.lsu_valid_o, 1'b0);
    cyc();
    bus.req0_valid_i = 0;
    #1;
    chk1("s1_vld_c1", bus.lsu_valid_o, 1'b1);
    chk32("s1_instr_c1", bus.lsu_instr_o, 32'hcad);
    chk1("s1_isload_c1", bus.lsu_is_load_o, 1'b1);
    chk1("s1_lbusy_c1", load_busy, 1'b1);
    cyc(); cyc(); cyc();
    cyc();
    bus.load_mem_resp_i = 1;
    #1;
    chk1("s1_lbusy_c5", load_busy, 1'b1);
    cyc();
    bus.load_mem_resp_i = 0;
    #1;
    chk1("s1_lbusy_c6", load_busy, 1'b0);
    chk1("s1_spurious", spurious, 1'b0);

    // Two continuous store requesters alternate, one store outstanding
    bus.req0_instr_i = 32'h100; bus.req0_is_load_i = 0;
    bus.req1_instr_i = 32'h200; bus.req1_is_load_i = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      bus.req0_valid_i = 1; bus.req1_valid_i = 1; bus.store_mem_resp_i = 0;
      #1;
      chk1("s2_rdy0_grant", bus.req0_ready_o, k != 1);
      chk1("s2_rdy1_grant", bus.req1_ready_o, k == 1);
      for (int j = 1; j <= 4; j++) begin
        cyc();
        bus.store_mem_resp_i = (j == 4);
        #1;
        chk1("s2_sbusy", store_busy, 1'b1);
        chk1("s2_rdy0_wait", bus.req0_ready_o, 1'b0);
        chk1("s2_rdy1_wait", bus.req1_ready_o, 1'b0);
        if (j == 1) chk32("s2_instr", bus.lsu_instr_o, (k == 1) ? 32'h200 : 32'h100);
      end
    end
    cyc();
    bus.req0_valid_i = 0; bus.req1_valid_i = 0; bus.store_mem_resp_i = 0;
    #1;
    chk1("s2_sbusy_end", store_busy, 1'b0);

    // Store-to-load hazard; non-aliasing load passes meanwhile
    cyc();
    bus.req0_valid_i = 1; bus.req0_instr_i = 32'hcad; bus.req0_is_load_i = 0;
    #1;
    chk1("s3_store_rdy", bus.req0_ready_o, 1'b1);
    cyc();
    bus.req0_instr_i = 32'h0ae; bus.req0_is_load_i = 1;
    bus.req1_valid_i = 1; bus.req1_instr_i = 32'h1cad; bus.req1_is_load_i = 1;
    #1;
    chk1("s3_sbusy", store_busy, 1'b1);
    chk1("s3_hazard_c1", hazard_stall, 1'b1);
    chk1("s3_rdy1_c1", bus.req1_ready_o, 1'b0);
    chk1("s3_rdy0_c1", bus.req0_ready_o, 1'b1);
    cyc();
    bus.req0_valid_i = 0; bus.load_mem_resp_i = 1;
    #1;
    chk1("s3_hazard_c2", hazard_stall, 1'b1);
    chk1("s3_rdy1_c2", bus.req1_ready_o, 1'b0);
    chk32("s3_instr_c2", bus.lsu_instr_o, 32'h0ae);
    cyc();
    bus.load_mem_resp_i = 0; bus.store_mem_resp_i = 1;
    #1;
    chk1("s3_lbusy_c3", load_busy, 1'b0);
    chk1("s3_hazard_c3", hazard_stall, 1'b1);
    chk1("s3_rdy1_c3", bus.req1_ready_o, 1'b0);
    cyc();
    bus.store_mem_resp_i = 0;
    #1;
    chk1("s3_sbusy_c4", store_busy, 1'b0);
    chk1("s3_hazard_c4", hazard_stall, 1'b0);
    chk1("s3_rdy1_c4", bus.req1_ready_o, 1'b1);
    cyc();
    bus.req1_valid_i = 0; bus.load_mem_resp_i = 1;
    #1;
    chk32("s3_instr_c5", bus.lsu_instr_o, 32'h1cad);
    chk1("s3_lbusy_c5", load_busy, 1'b1);
    cyc();
    bus.load_mem_resp_i = 0;
    #1;
    chk1("s3_lbusy_c6", load_busy, 1'b0);

    // LSU back-pressure holds the payload; drain cycle allows a refill
    cyc();
    bus.req0_valid_i = 1; bus.req0_instr_i = 32'h040; bus.req0_is_load_i = 0;
    #1;
    chk1("s4_rdy0", bus.req0_ready_o, 1'b1);
    for (int j = 1; j <= 4; j++) begin
      cyc();
      bus.req0_valid_i = 0; bus.lsu_ready_i = 0;
      bus.req1_valid_i = 1; bus.req1_instr_i = 32'h123; bus.req1_is_load_i = 1;
      #1;
      chk1("s4_vld_hold", bus.lsu_valid_o, 1'b1);
      chk32("s4_instr_hold", bus.lsu_instr_o, 32'h040);
      chk1("s4_rdy1_stall", bus.req1_ready_o, 1'b0);
    end
    cyc();
    bus.lsu_ready_i = 1;
    #1;
    chk1("s4_rdy1_drain", bus.req1_ready_o, 1'b1);
    chk32("s4_instr_drain", bus.lsu_instr_o, 32'h040);
    cyc();
    bus.req1_valid_i = 0; bus.load_mem_resp_i = 1; bus.store_mem_resp_i = 1;
    #1;
    chk32("s4_instr_refill", bus.lsu_instr_o, 32'h123);
    chk1("s4_isload_refill", bus.lsu_is_load_o, 1'b1);
    chk1("s4_lbusy", load_busy, 1'b1);
    chk1("s4_sbusy", store_busy, 1'b1);
    cyc();
    bus.load_mem_resp_i = 0; bus.store_mem_resp_i = 0;
    #1;
    chk1("s4_lbusy_clr", load_busy, 1'b0);
    chk1("s4_sbusy_clr", store_busy, 1'b0);
    chk1("s4_spurious", spurious, 1'b0);

    // Timeout on a load left without response, then a stray store response
    cyc();
    bus.req0_valid_i = 1; bus.req0_instr_i = 32'h777; bus.req0_is_load_i = 1;
    #1;
    chk1("s5_rdy0", bus.req0_ready_o, 1'b1);
    for (int k = 1; k <= 64; k++) begin
      cyc();
      bus.req0_valid_i = 0;
      #1;
      if (k == 63) chk1("s5_timeout_63", timeout, 1'b0);
      if (k == 64) chk1("s5_timeout_64", timeout, 1'b1);
    end
    cyc();
    bus.load_mem_resp_i = 1;
    #1;
    cyc();
    bus.load_mem_resp_i = 0;
    #1;
    chk1("s5_lbusy_after", load_busy, 1'b0);
    chk1("s5_timeout_sticky", timeout, 1'b1);
    cyc();
    bus.store_mem_resp_i = 1;
    #1;
    chk1("s5_spurious_pre", spurious, 1'b0);
    cyc();
    bus.store_mem_resp_i = 0;
    #1;
    chk1("s5_spurious", spurious, 1'b1);
    chk1("s5_sbusy_idle", store_busy, 1'b0);

    // Async reset with both slots busy and the issue register full
    cyc();
    bus.req0_valid_i = 1; bus.req0_instr_i = 32'h111; bus.req0_is_load_i = 1;
    bus.req1_valid_i = 1; bus.req1_instr_i = 32'h222; bus.req1_is_load_i = 0;
    #1;
    chk1("s6_rdy1_rr", bus.req1_ready_o, 1'b1);
    chk1("s6_rdy0_rr", bus.req0_ready_o, 1'b0);
    cyc();
    bus.req1_valid_i = 0;
    #1;
    chk1("s6_rdy0_next", bus.req0_ready_o, 1'b1);
    cyc();
    bus.req0_valid_i = 0; bus.lsu_ready_i = 0;
    #1;
    chk1("s6_vld_pre", bus.lsu_valid_o, 1'b1);
    chk1("s6_lbusy_pre", load_busy, 1'b1);
    chk1("s6_sbusy_pre", store_busy, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk1("s6_rst_vld", bus.lsu_valid_o, 1'b0);
    chk32("s6_rst_instr", bus.lsu_instr_o, 32'h0);
    chk1("s6_rst_isload", bus.lsu_is_load_o, 1'b0);
    chk1("s6_rst_lbusy", load_busy, 1'b0);
    chk1("s6_rst_sbusy", store_busy, 1'b0);
    chk1("s6_rst_timeout", timeout, 1'b0);
    chk1("s6_rst_spurious", spurious, 1'b0);
    chk1("s6_rst_hazard", hazard_stall, 1'b0);
    chk1("s6_rst_rdy0", bus.req0_ready_o, 1'b0);
    chk1("s6_rst_rdy1", bus.req1_ready_o, 1'b0);
    cyc();
    rst = 1'b0; bus.lsu_ready_i = 1;
    bus.req0_valid_i = 1; bus.req0_instr_i = 32'h300; bus.req0_is_load_i = 0;
    bus.req1_valid_i = 1; bus.req1_instr_i = 32'h400; bus.req1_is_load_i = 0;
    #1;
    chk1("s6_post_rdy0", bus.req0_ready_o, 1'b1);
    chk1("s6_post_rdy1", bus.req1_ready_o, 1'b0);
    cyc();
    bus.req0_valid_i = 0; bus.req1_valid_i = 0;
    #1;
    chk32("s6_post_instr", bus.lsu_instr_o, 32'h300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
